// File: rtl/sid_regs.sv
// sid_regs: SID-style register file for three voices plus filter/volume.
//   clk, reset (async, active-low)      - clock and reset
//   tick                                - 1 MHz phase enable for the bus-latch decay counter
//   cs, rw, addr, data_in               - access port (one access per cs cycle; rw=1 read)
//   data_out                            - registered read data, held between reads
//   potx, poty, osc3, env3              - read-only sources at 0x19-0x1C
//   freq, pw, control, attack_decay,
//   sustain_release, fc, res_filt,
//   mode_vol                            - register contents, one slice per voice
module sid_regs #(
    parameter int unsigned DECAY_TICKS = 8191
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        cs,
    input  logic        rw,
    input  logic [4:0]  addr,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    input  logic [7:0]  potx,
    input  logic [7:0]  poty,
    input  logic [7:0]  osc3,
    input  logic [7:0]  env3,
    output logic [47:0] freq,
    output logic [35:0] pw,
    output logic [23:0] control,
    output logic [23:0] attack_decay,
    output logic [23:0] sustain_release,
    output logic [10:0] fc,
    output logic [7:0]  res_filt,
    output logic [7:0]  mode_vol
);

    localparam int unsigned NUM_VOICES = 3;
    localparam int unsigned VOICE_REGS = 7;
    localparam int unsigned NUM_WREGS  = 25;
    localparam int unsigned CNT_W      = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS + 1) : 1;

    localparam logic [4:0] ADDR_FC_LO  = 5'h15;
    localparam logic [4:0] ADDR_FC_HI  = 5'h16;
    localparam logic [4:0] ADDR_RESF   = 5'h17;
    localparam logic [4:0] ADDR_MODEV  = 5'h18;
    localparam logic [4:0] ADDR_POTX   = 5'h19;
    localparam logic [4:0] ADDR_POTY   = 5'h1A;
    localparam logic [4:0] ADDR_OSC3   = 5'h1B;
    localparam logic [4:0] ADDR_ENV3   = 5'h1C;

    // Per-voice register storage
    logic [7:0]       r_freq_lo [NUM_VOICES];
    logic [7:0]       r_freq_hi [NUM_VOICES];
    logic [7:0]       r_pw_lo   [NUM_VOICES];
    logic [3:0]       r_pw_hi   [NUM_VOICES];
    logic [7:0]       r_control [NUM_VOICES];
    logic [7:0]       r_ad      [NUM_VOICES];
    logic [7:0]       r_sr      [NUM_VOICES];

    // Filter / volume storage
    logic [2:0]       r_fc_lo;
    logic [7:0]       r_fc_hi;
    logic [7:0]       r_res_filt;
    logic [7:0]       r_mode_vol;

    // Bus latch, its decay counter and the read data register
    logic [7:0]       r_latch;
    logic [CNT_W-1:0] r_decay_cnt;
    logic [7:0]       r_data_out;

    logic             w_wr;
    logic             w_rd;
    logic [NUM_WREGS-1:0] w_sel;
    logic [7:0]       w_rd_data;

    // Access qualification and one-hot write-enable decode for 0x00-0x18
    always_comb begin
        w_wr  = cs & ~rw;
        w_rd  = cs & rw;
        w_sel = '0;
        for (int i = 0; i < int'(NUM_WREGS); i++) begin
            w_sel[i] = w_wr && (addr == 5'(i));
        end
    end

    // Voice registers; each voice occupies seven consecutive addresses from 7n
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                r_freq_lo[v] <= '0;
                r_freq_hi[v] <= '0;
                r_pw_lo[v]   <= '0;
                r_pw_hi[v]   <= '0;
                r_control[v] <= '0;
                r_ad[v]      <= '0;
                r_sr[v]      <= '0;
            end
        end else begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (w_sel[VOICE_REGS*v + 0]) r_freq_lo[v] <= data_in;
                if (w_sel[VOICE_REGS*v + 1]) r_freq_hi[v] <= data_in;
                if (w_sel[VOICE_REGS*v + 2]) r_pw_lo[v]   <= data_in;
                if (w_sel[VOICE_REGS*v + 3]) r_pw_hi[v]   <= data_in[3:0];
                if (w_sel[VOICE_REGS*v + 4]) r_control[v] <= data_in;
                if (w_sel[VOICE_REGS*v + 5]) r_ad[v]      <= data_in;
                if (w_sel[VOICE_REGS*v + 6]) r_sr[v]      <= data_in;
            end
        end
    end

    // Filter cutoff, resonance/routing and mode/volume registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fc_lo    <= '0;
            r_fc_hi    <= '0;
            r_res_filt <= '0;
            r_mode_vol <= '0;
        end else begin
            if (w_sel[ADDR_FC_LO]) r_fc_lo    <= data_in[2:0];
            if (w_sel[ADDR_FC_HI]) r_fc_hi    <= data_in;
            if (w_sel[ADDR_RESF])  r_res_filt <= data_in;
            if (w_sel[ADDR_MODEV]) r_mode_vol <= data_in;
        end
    end

    // Bus latch: every write reloads it; a write beats a same-cycle tick.
    // Reads never touch it, so a tick during a read still decrements.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_latch     <= '0;
            r_decay_cnt <= '0;
        end else if (w_wr) begin
            r_latch     <= data_in;
            r_decay_cnt <= CNT_W'(DECAY_TICKS);
        end else if (tick && (r_decay_cnt != '0)) begin
            r_decay_cnt <= r_decay_cnt - CNT_W'(1);
            if (r_decay_cnt == CNT_W'(1)) begin
                r_latch <= '0;
            end
        end
    end

    // Read source select; uses the pre-tick latch value
    always_comb begin
        w_rd_data = r_latch;
        unique case (addr)
            ADDR_POTX: w_rd_data = potx;
            ADDR_POTY: w_rd_data = poty;
            ADDR_OSC3: w_rd_data = osc3;
            ADDR_ENV3: w_rd_data = env3;
            default:   w_rd_data = r_latch;
        endcase
    end

    // Read data register, held until the next read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out <= '0;
        end else if (w_rd) begin
            r_data_out <= w_rd_data;
        end
    end

    // Pack register contents onto the per-voice output buses
    always_comb begin
        freq            = '0;
        pw              = '0;
        control         = '0;
        attack_decay    = '0;
        sustain_release = '0;
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            freq[16*v +: 16]           = {r_freq_hi[v], r_freq_lo[v]};
            pw[12*v +: 12]             = {r_pw_hi[v], r_pw_lo[v]};
            control[8*v +: 8]          = r_control[v];
            attack_decay[8*v +: 8]     = r_ad[v];
            sustain_release[8*v +: 8]  = r_sr[v];
        end
        fc       = {r_fc_hi, r_fc_lo};
        res_filt = r_res_filt;
        mode_vol = r_mode_vol;
        data_out = r_data_out;
    end

endmodule

// File: tb/tb_sid_regs.sv
// tb_sid_regs: directed and randomized checks of sid_regs against a
// byte-addressed reference model of the register map and bus latch.
module tb_sid_regs;

    localparam int unsigned DT = 4;

    logic        clk;
    logic        reset;
    logic        tick;
    logic        cs;
    logic        rw;
    logic [4:0]  addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic [7:0]  potx, poty, osc3, env3;
    logic [47:0] freq;
    logic [35:0] pw;
    logic [23:0] control, attack_decay, sustain_release;
    logic [10:0] fc;
    logic [7:0]  res_filt, mode_vol;

    sid_regs #(.DECAY_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .cs(cs), .rw(rw),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .potx(potx), .poty(poty), .osc3(osc3), .env3(env3),
        .freq(freq), .pw(pw), .control(control),
        .attack_decay(attack_decay), .sustain_release(sustain_release),
        .fc(fc), .res_filt(res_filt), .mode_vol(mode_vol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the register map as 25 bytes plus latch/counter
    logic [7:0] m_reg [0:24];
    logic [7:0] m_latch;
    logic [7:0] m_dout;
    int         m_cnt;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 25; i++) m_reg[i] = 8'h00;
        m_latch = 8'h00;
        m_dout  = 8'h00;
        m_cnt   = 0;
    endtask

    function automatic logic [7:0] wmask(input logic [4:0] a);
        if (a == 5'd3 || a == 5'd10 || a == 5'd17) return 8'h0F;
        if (a == 5'h15) return 8'h07;
        return 8'hFF;
    endfunction

    // Expected effect of the current inputs at the coming clock edge
    task automatic model_step();
        if (cs && !rw) begin
            if (addr <= 5'h18) m_reg[addr] = data_in & wmask(addr);
            m_latch = data_in;
            m_cnt   = DT;
        end else begin
            if (cs && rw) begin
                case (addr)
                    5'h19:   m_dout = potx;
                    5'h1A:   m_dout = poty;
                    5'h1B:   m_dout = osc3;
                    5'h1C:   m_dout = env3;
                    default: m_dout = m_latch;
                endcase
            end
            if (tick && m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_latch = 8'h00;
            end
        end
    endtask

    task automatic check_all();
        logic [47:0] e_freq;
        logic [35:0] e_pw;
        logic [23:0] e_ctl, e_ad, e_sr;
        for (int v = 0; v < 3; v++) begin
            e_freq[16*v +: 16] = {m_reg[7*v+1], m_reg[7*v]};
            e_pw[12*v +: 12]   = {m_reg[7*v+3][3:0], m_reg[7*v+2]};
            e_ctl[8*v +: 8]    = m_reg[7*v+4];
            e_ad[8*v +: 8]     = m_reg[7*v+5];
            e_sr[8*v +: 8]     = m_reg[7*v+6];
        end
        check("data_out", 48'(data_out), 48'(m_dout));
        check("freq", freq, e_freq);
        check("pw", 48'(pw), 48'(e_pw));
        check("control", 48'(control), 48'(e_ctl));
        check("attack_decay", 48'(attack_decay), 48'(e_ad));
        check("sustain_release", 48'(sustain_release), 48'(e_sr));
        check("fc", 48'(fc), 48'({m_reg[22], m_reg[21][2:0]}));
        check("res_filt", 48'(res_filt), 48'(m_reg[23]));
        check("mode_vol", 48'(mode_vol), 48'(m_reg[24]));
    endtask

    task automatic step(input logic c, input logic r, input logic [4:0] a,
                        input logic [7:0] d, input logic t);
        cs = c; rw = r; addr = a; data_in = d; tick = t;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        step(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd(input logic [4:0] a);
        step(1'b1, 1'b1, a, 8'h00, 1'b0);
    endtask

    task automatic tk();
        step(1'b0, 1'b0, 5'h00, 8'h00, 1'b1);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; cs = 1'b0; rw = 1'b0; addr = '0; data_in = '0;
        potx = 8'h11; poty = 8'h22; osc3 = 8'h3C; env3 = 8'h80;
        model_reset();
        #3;
        check_all();
        reset = 1'b1;

        // Voice 0 frequency; other voices untouched
        wr(5'h00, 8'h34);
        wr(5'h01, 8'h12);
        check("freq_v0", 48'(freq[15:0]), 48'h1234);
        check("freq_v12", 48'(freq[47:16]), 48'h0);

        // Masked writes and readback through the latch
        wr(5'h03, 8'hFF);
        wr(5'h15, 8'hFF);
        check("pw_hi_v0", 48'(pw[11:8]), 48'hF);
        check("fc_lo", 48'(fc[2:0]), 48'h7);
        rd(5'h03);
        check("rd_latch", 48'(data_out), 48'hFF);

        // Decay of the latch
        wr(5'h1F, 8'hA5);
        tk(); tk(); tk();
        rd(5'h00);
        check("decay_3", 48'(data_out), 48'hA5);
        tk();
        rd(5'h00);
        check("decay_4", 48'(data_out), 48'h00);
        tk(); tk();
        rd(5'h1D);
        check("decay_hold", 48'(data_out), 48'h00);

        // Read-only sources leave the latch alone
        wr(5'h1E, 8'h77);
        rd(5'h1C);
        check("env3", 48'(data_out), 48'h80);
        rd(5'h1B);
        check("osc3", 48'(data_out), 48'h3C);
        rd(5'h02);
        check("latch_kept", 48'(data_out), 48'h77);

        // Write wins over a tick at counter=1
        wr(5'h1F, 8'h11);
        tk(); tk(); tk();
        step(1'b1, 1'b0, 5'h1F, 8'h5A, 1'b1);
        rd(5'h00);
        check("wr_tick", 48'(data_out), 48'h5A);
        tk(); tk(); tk();
        // Read and clearing tick together: pre-tick value, then cleared
        step(1'b1, 1'b1, 5'h00, 8'h00, 1'b1);
        check("rd_tick", 48'(data_out), 48'h5A);
        rd(5'h00);
        check("rd_after_clear", 48'(data_out), 48'h00);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            potx = 8'($urandom); poty = 8'($urandom);
            osc3 = 8'($urandom); env3 = 8'($urandom);
            step(1'(($urandom_range(0, 3) != 0)), 1'($urandom), 5'($urandom),
                 8'($urandom), 1'(($urandom_range(0, 2) == 0)));
        end

        // Reset asserted mid-decay, between clock edges
        wr(5'h04, 8'h41);
        rd(5'h04);
        wr(5'h1F, 8'hC3);
        tk();
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        check("rst_control", 48'(control), 48'h0);
        #3;
        reset = 1'b1;
        tk(); tk(); tk(); tk(); tk();
        rd(5'h00);
        check("rst_no_pending", 48'(data_out), 48'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sid_regs.md
SID_REGS -- requirements
Module: sid_regs

Interface
REQ-001 Parameter DECAY_TICKS, default 8191, tick count before the write-only read latch decays to 0x00.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 tick  input  1  one-cycle 1 MHz phase enable, used only by the decay counter.
REQ-005 cs  input  1  access strobe; each clk cycle with cs=1 is one access.
REQ-006 rw  input  1  1=read, 0=write; sampled only when cs=1.
REQ-007 addr  input  5  register address 0x00-0x1F.
REQ-008 data_in  input  8  write data.
REQ-009 data_out  output  8  registered read data.
REQ-010 potx, poty, osc3, env3  input  8 each  read-only sources for 0x19-0x1C; env3 is voice-3 envelope output.
REQ-011 freq  output  48  voice n frequency at bits [16n+15:16n], n=0..2.
REQ-012 pw  output  36  voice n pulse width at bits [12n+11:12n].
REQ-013 control, attack_decay, sustain_release  output  24 each  voice n byte at bits [8n+7:8n].
REQ-014 fc  output  11  filter cutoff {reg 0x16, reg 0x15[2:0]}.
REQ-015 res_filt, mode_vol  output  8 each  registers 0x17, 0x18.

Function
REQ-016 Voice n register base SHALL be 7n: +0 freq lo, +1 freq hi, +2 pw lo, +3 pw hi[3:0], +4 control, +5 attack_decay, +6 sustain_release.
REQ-017 A write (cs=1, rw=0) to 0x00-0x18 SHALL update the addressed register; the new value is visible on outputs the following cycle.
REQ-018 Writes to pw hi SHALL store data_in[3:0] only; writes to 0x15 SHALL store data_in[2:0] only; upper bits dropped.
REQ-019 Writes to 0x19-0x1F SHALL not change any register but SHALL update the bus latch (REQ-021).
REQ-020 A read (cs=1, rw=1) of 0x19/0x1A/0x1B/0x1C SHALL load potx/poty/osc3/env3 into data_out one cycle later.
REQ-021 Every write SHALL load data_in into an 8-bit bus latch and load the decay counter with DECAY_TICKS.
REQ-022 A read of 0x00-0x18 or 0x1D-0x1F SHALL load the bus latch into data_out one cycle later.
REQ-023 Reads SHALL not modify any register, the bus latch or the decay counter.
REQ-024 data_out SHALL hold its value until the next read access.
REQ-025 Decay counter SHALL decrement by 1 on each tick while nonzero; on the tick taking it 1->0 the bus latch SHALL clear to 0x00.
REQ-026 Counter at 0 SHALL stay at 0 (no wrap); latch stays 0x00.
REQ-027 Write and tick in same cycle: the write SHALL win (counter=DECAY_TICKS, latch=data_in, no decrement).
REQ-028 Read and tick in same cycle: data_out SHALL take the pre-tick latch value; the decrement and any clear still occur.
REQ-029 Accesses with cs=0 SHALL have no effect; tick alone SHALL affect only the decay counter and latch.
REQ-030 Back-to-back accesses on consecutive cycles SHALL each complete; a read directly after a write to the same address returns the new value via the latch.

Reset
REQ-031 While reset=0: all voice and filter registers, the bus latch, the decay counter and data_out SHALL be 0, independent of clk.
REQ-032 Deassertion SHALL be effective at the first clk edge after reset goes high.
REQ-033 Reset asserted mid-decay SHALL clear the counter and latch at once; no pending clear occurs afterwards.

Verification
REQ-034 Write 0x34 to 0x00 and 0x12 to 0x01 -> freq[15:0]=0x1234 next cycle; other voices unchanged.
REQ-035 Write 0xFF to 0x03 and 0xFF to 0x15 -> pw[11:8]=0xF, fc[2:0]=0x7; read 0x03 -> data_out=0xFF (latch).
REQ-036 With DECAY_TICKS=4, write 0xA5, apply 3 ticks, read -> 0xA5; 4th tick, read -> 0x00; further ticks leave 0x00.
REQ-037 Set env3=0x80 and osc3=0x3C; read 0x1C -> 0x80, read 0x1B -> 0x3C; latch and counter unchanged.
REQ-038 Write 0x5A on the same cycle as a tick with counter=1 -> latch=0x5A, counter=DECAY_TICKS, no clear.
REQ-039 Write 0x41 to 0x04, assert reset for one half-cycle -> control=0x00, data_out=0x00 immediately.
